exp_mask_unpack_ctrl: RTL

Parametrised successor to the ML-DSA ExpandMask sampler controller. It accepts a raw SHAKE256 squeeze stream of fixed-width words and buffers and bit-unpacks it into gamma1-width samples. Each sample is mapped to (gamma1 - x) mod q, and exactly one polynomial of NUM_COEFF coefficients is emitted, NUM_SAMPLES per cycle. It runs selectable gamma1 modes (18-bit or 20-bit samples), applies real backpressure, and signals completion. It sits between the Keccak squeeze path and the y-polynomial memory write port.

---
 rtl/exp_mask_unpack_ctrl_if.sv | 36 +++
 rtl/exp_mask_unpack_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/exp_mask_unpack_ctrl_if.sv
// Stream bundle for exp_mask_unpack_ctrl.
//   slave  : the unpacker (consumes squeeze words, produces coefficient groups)
//   master : the environment (squeeze source and coefficient sink)
// Signals:
//   data_valid_i / data_hold_o / data_i : squeeze word handshake, LSB first
//   data_valid_o / data_o / done_o      : coefficient group output and completion pulse
interface exp_mask_unpack_ctrl_if #(
  parameter int unsigned DATA_W       = 80,
  parameter int unsigned NUM_SAMPLES  = 4,
  parameter int unsigned VLD_SAMPLE_W = 23
);
  logic                                        data_valid_i;
  logic                                        data_hold_o;
  logic [DATA_W-1:0]                           data_i;
  logic                                        data_valid_o;
  logic [NUM_SAMPLES-1:0][VLD_SAMPLE_W-1:0]    data_o;
  logic                                        done_o;

  modport slave (
    input  data_valid_i,
    input  data_i,
    output data_hold_o,
    output data_valid_o,
    output data_o,
    output done_o
  );

  modport master (
    output data_valid_i,
    output data_i,
    input  data_hold_o,
    input  data_valid_o,
    input  data_o,
    input  done_o
  );
endinterface

// File: rtl/exp_mask_unpack_ctrl.sv
// ExpandMask sampler controller: buffers a SHAKE256 squeeze stream, unpacks it
// into 18- or 20-bit samples and emits one polynomial of (gamma1 - x) mod q
// coefficients, NUM_SAMPLES per valid cycle, then pulses done_o.
// Ports:
//   clk      : clock
//   rst_b    : synchronous active-low reset
//   zeroize  : synchronous clear, same effect as reset
//   en_i     : start pulse, honoured only in IDLE
//   mode_i   : 0 -> gamma1=2^17 (18-bit samples), 1 -> gamma1=2^19 (20-bit samples)
//   bus      : slave side of the squeeze-in / coefficient-out stream
module exp_mask_unpack_ctrl #(
  parameter int unsigned DATA_W       = 80,
  parameter int unsigned NUM_SAMPLES  = 4,
  parameter int unsigned VLD_SAMPLE_W = 23,
  parameter int unsigned BUF_W        = 160,
  parameter int unsigned NUM_COEFF    = 256,
  parameter int unsigned MLDSA_Q      = 8380417
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   zeroize,
  input  logic                   en_i,
  input  logic                   mode_i,
  exp_mask_unpack_ctrl_if.slave  bus
);

  localparam int unsigned SW_LO      = 18;
  localparam int unsigned SW_HI      = 20;
  localparam int unsigned GAMMA1_LO  = 32'd1 << 17;
  localparam int unsigned GAMMA1_HI  = 32'd1 << 19;
  localparam int unsigned FILL_W     = $clog2(BUF_W + 1);
  localparam int unsigned SUM_W      = FILL_W + 1;
  localparam int unsigned NUM_GROUPS = NUM_COEFF / NUM_SAMPLES;
  localparam int unsigned GRP_W      = $clog2(NUM_GROUPS + 1);
  localparam int unsigned ARITH_W    = VLD_SAMPLE_W + 2;

  localparam logic [FILL_W-1:0] CONS_LO  = FILL_W'(NUM_SAMPLES * SW_LO);
  localparam logic [FILL_W-1:0] CONS_HI  = FILL_W'(NUM_SAMPLES * SW_HI);
  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [NUM_SAMPLES-1:0][VLD_SAMPLE_W-1:0] grp_t;

  state_t             r_state;
  logic               r_mode;
  logic [BUF_W-1:0]   r_buf;
  logic [FILL_W-1:0]  r_fill;
  logic [GRP_W-1:0]   r_grp;
  logic               r_hold;
  logic               r_data_valid;
  grp_t               r_data;
  logic               r_done;

  logic [FILL_W-1:0]  w_consume;
  logic               w_emit;
  logic               w_accept;
  logic               w_last;
  logic [FILL_W-1:0]  w_fill_post;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic [GRP_W-1:0]   w_grp_nxt;
  logic [BUF_W-1:0]   w_buf_nxt;
  grp_t               w_coeff;

  // Hold for a RUN cycle given that cycle's fill and group position. The cycle
  // that emits the last group also holds: its buffer is discarded on entry to DONE.
  function automatic logic f_hold(input logic [FILL_W-1:0] fill,
                                  input logic [FILL_W-1:0] cons,
                                  input logic              last_pend);
    logic              emit_n;
    logic [FILL_W-1:0] post;
    emit_n = (fill >= cons);
    post   = emit_n ? (fill - cons) : fill;
    return (emit_n && last_pend) ||
           ((SUM_W'(post) + SUM_W'(DATA_W)) > SUM_W'(BUF_W));
  endfunction

  // Datapath for this cycle: consume, then append at the post-consume fill.
  assign w_consume   = r_mode ? CONS_HI : CONS_LO;
  assign w_emit      = (r_state == ST_RUN) && (r_fill >= w_consume);
  assign w_accept    = (r_state == ST_RUN) && bus.data_valid_i && !r_hold;
  assign w_last      = w_emit && (r_grp == LAST_GRP);
  assign w_fill_post = w_emit ? (r_fill - w_consume) : r_fill;
  assign w_fill_nxt  = w_accept ? (w_fill_post + FILL_W'(DATA_W)) : w_fill_post;
  assign w_grp_nxt   = r_grp + GRP_W'(w_emit);

  // Bits above fill are always zero, so the new word can simply be OR-ed in.
  always_comb begin : p_buf_nxt
    w_buf_nxt = w_emit ? (r_buf >> w_consume) : r_buf;
    if (w_accept) begin
      w_buf_nxt = w_buf_nxt | (BUF_W'(bus.data_i) << w_fill_post);
    end
  end

  // Per-sample (gamma1 - x) mod q; x < 2*gamma1 so one conditional add of q suffices.
  always_comb begin : p_coeff
    logic [SW_HI-1:0]   x;
    logic [ARITH_W-1:0] gam;
    logic [ARITH_W-1:0] xe;
    logic [ARITH_W-1:0] res;
    gam     = r_mode ? ARITH_W'(GAMMA1_HI) : ARITH_W'(GAMMA1_LO);
    w_coeff = '0;
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      x   = r_mode ? r_buf[SW_HI*k +: SW_HI] : SW_HI'(r_buf[SW_LO*k +: SW_LO]);
      xe  = ARITH_W'(x);
      res = (xe > gam) ? (gam + ARITH_W'(MLDSA_Q) - xe) : (gam - xe);
      w_coeff[k] = VLD_SAMPLE_W'(res);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_b || zeroize) begin
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_buf        <= '0;
      r_fill       <= '0;
      r_grp        <= '0;
      r_hold       <= 1'b1;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_hold <= 1'b1;
          if (en_i) begin
            r_state <= ST_RUN;
            r_mode  <= mode_i;
            r_buf   <= '0;
            r_fill  <= '0;
            r_grp   <= '0;
            r_hold  <= f_hold('0, mode_i ? CONS_HI : CONS_LO, LAST_GRP == '0);
          end
        end
        ST_RUN: begin
          r_buf  <= w_buf_nxt;
          r_fill <= w_fill_nxt;
          r_grp  <= w_grp_nxt;
          r_hold <= f_hold(w_fill_nxt, w_consume, w_grp_nxt == LAST_GRP);
          if (w_emit) begin
            r_data_valid <= 1'b1;
            r_data       <= w_coeff;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_buf   <= '0;
            r_fill  <= '0;
            r_hold  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_hold  <= 1'b1;
          r_grp   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_hold  <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_hold_o  = r_hold;
  assign bus.data_valid_o = r_data_valid;
  assign bus.data_o       = r_data;
  assign bus.done_o       = r_done;

endmodule
